// File: rtl/cv32e40x_instr_aligner.sv
// Halfword-granular instruction aligner: buffers 32-bit fetch words and hands out one
// compressed (zero-extended) or full 32-bit instruction per handshake, tracking its PC.
module cv32e40x_instr_aligner #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_is_compressed_o,
  output logic        instr_bus_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]      wordMem_q [DEPTH];
  logic [DEPTH-1:0] wordErr_q;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:1]      pc_q, pc_d;
  logic             halt_q, halt_d;

  logic [PW-1:0] rdPtrNext;
  logic [31:0]   w0, w1;
  logic          w0Err, w1Err;
  logic          w0Present, w1Present;
  logic [15:0]   hw;
  logic          push, pop, accept;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdPtrNext = ptrInc(rdPtr_q);
  assign w0        = wordMem_q[rdPtr_q];
  assign w1        = wordMem_q[rdPtrNext];
  assign w0Err     = wordErr_q[rdPtr_q];
  assign w1Err     = wordErr_q[rdPtrNext];
  assign w0Present = (count_q != '0);
  assign w1Present = (count_q >= CW'(2));
  assign hw        = w0[31:16];

  assign fetch_ready_o = (count_q < CW'(DEPTH)) && !halt_q;
  assign push          = fetch_valid_i && fetch_ready_o && !branch_i;
  assign accept        = instr_valid_o && instr_ready_i && !branch_i;
  assign instr_addr_o  = {pc_q, 1'b0};

  // An erroneous head word is presented immediately, without waiting for a second word.
  always_comb begin
    instr_valid_o         = 1'b0;
    instr_rdata_o         = '0;
    instr_is_compressed_o = 1'b0;
    instr_bus_err_o       = 1'b0;
    if (w0Present && !halt_q) begin
      if (w0Err) begin
        instr_valid_o   = 1'b1;
        instr_bus_err_o = 1'b1;
        instr_rdata_o   = pc_q[1] ? {16'h0, hw} : w0;
      end else if (!pc_q[1]) begin
        instr_valid_o         = 1'b1;
        instr_is_compressed_o = (w0[1:0] != 2'b11);
        instr_rdata_o         = instr_is_compressed_o ? {16'h0, w0[15:0]} : w0;
      end else if (hw[1:0] != 2'b11) begin
        instr_valid_o         = 1'b1;
        instr_is_compressed_o = 1'b1;
        instr_rdata_o         = {16'h0, hw};
      end else if (w1Present) begin
        instr_valid_o   = 1'b1;
        instr_rdata_o   = {w1[15:0], hw};
        instr_bus_err_o = w1Err;
      end
    end
  end

  // Only a compressed instruction in the low half leaves the head word in place.
  always_comb begin
    pop     = 1'b0;
    pc_d    = pc_q;
    halt_d  = halt_q;
    if (branch_i) begin
      pc_d   = branch_addr_i[31:1];
      halt_d = 1'b0;
    end else if (accept) begin
      if (instr_bus_err_o) begin
        halt_d = 1'b1;
      end else begin
        pc_d = pc_q + (instr_is_compressed_o ? 31'd1 : 31'd2);
        pop  = pc_q[1] || !instr_is_compressed_o;
      end
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (branch_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rdPtr_d = rdPtrNext;
      end
      if (push) begin
        wrPtr_d = ptrInc(wrPtr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        wordMem_q[i] <= '0;
      end
      wordErr_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      pc_q      <= '0;
      halt_q    <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      if (push) begin
        wordMem_q[wrPtr_q] <= fetch_rdata_i;
        wordErr_q[wrPtr_q] <= fetch_err_i;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
// Directed bench for cv32e40x_instr_aligner: hand-computed vectors checked with
// immediate assertions; inputs change 1ns after the rising edge, outputs checked before the next.
module tb_cv32e40x_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchRdata;
  logic        fetchErr;
  logic        branch;
  logic [31:0] branchAddr;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instrRdata;
  logic [31:0] instrAddr;
  logic        instrCompressed;
  logic        instrBusErr;

  int checks = 0;
  int errors = 0;

  cv32e40x_instr_aligner #(.DEPTH(3)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .fetch_valid_i         (fetchValid),
    .fetch_ready_o         (fetchReady),
    .fetch_rdata_i         (fetchRdata),
    .fetch_err_i           (fetchErr),
    .branch_i              (branch),
    .branch_addr_i         (branchAddr),
    .instr_valid_o         (instrValid),
    .instr_ready_i         (instrReady),
    .instr_rdata_o         (instrRdata),
    .instr_addr_o          (instrAddr),
    .instr_is_compressed_o (instrCompressed),
    .instr_bus_err_o       (instrBusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic fe,
                               input logic br, input logic [31:0] ba, input logic rdy);
    fetchValid = fv;
    fetchRdata = fd;
    fetchErr   = fe;
    branch     = br;
    branchAddr = ba;
    instrReady = rdy;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #12;
    checkOutput("rst_valid", instrValid, 0);
    checkOutput("rst_fready", fetchReady, 1);
    checkOutput("rst_rdata", instrRdata, 0);
    checkOutput("rst_addr", instrAddr, 0);
    checkOutput("rst_comp", instrCompressed, 0);
    checkOutput("rst_err", instrBusErr, 0);
    rst_n = 1'b1;
    stepClock();

    // Sequential fetch from 0x100: 32-bit then two compressed halves
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    stepClock();
    checkOutput("br100_valid", instrValid, 0);
    checkOutput("br100_addr", instrAddr, 32'h100);
    applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("br100_fready", fetchReady, 1);
    stepClock();
    applyStimulus(1'b1, 32'h4505_4501, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("i0_valid", instrValid, 1);
    checkOutput("i0_rdata", instrRdata, 32'h0050_0093);
    checkOutput("i0_addr", instrAddr, 32'h100);
    checkOutput("i0_comp", instrCompressed, 0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("i1_rdata", instrRdata, 32'h0000_4501);
    checkOutput("i1_addr", instrAddr, 32'h104);
    checkOutput("i1_comp", instrCompressed, 1);
    stepClock();
    checkOutput("i2_valid", instrValid, 1);
    checkOutput("i2_rdata", instrRdata, 32'h0000_4505);
    checkOutput("i2_addr", instrAddr, 32'h106);
    checkOutput("i2_comp", instrCompressed, 1);
    stepClock();
    checkOutput("i3_valid", instrValid, 0);
    checkOutput("i3_rdata", instrRdata, 0);
    checkOutput("i3_addr", instrAddr, 32'h108);

    // Straddling 32-bit instruction at 0x202
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h202, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h0093_1234, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    checkOutput("st_half_valid", instrValid, 0);
    checkOutput("st_half_rdata", instrRdata, 0);
    applyStimulus(1'b1, 32'hABCD_0050, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("st_valid", instrValid, 1);
    checkOutput("st_rdata", instrRdata, 32'h0050_0093);
    checkOutput("st_addr", instrAddr, 32'h202);
    checkOutput("st_comp", instrCompressed, 0);
    stepClock();
    checkOutput("st_next_rdata", instrRdata, 32'h0000_ABCD);
    checkOutput("st_next_addr", instrAddr, 32'h206);
    checkOutput("st_next_comp", instrCompressed, 1);
    stepClock();
    checkOutput("st_empty_valid", instrValid, 0);
    checkOutput("st_empty_addr", instrAddr, 32'h208);

    // Fill to DEPTH with consumer stalled
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h1111_1113, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h2222_2223, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fill_fready2", fetchReady, 1);
    stepClock();
    applyStimulus(1'b1, 32'h4444_4443, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_fready", fetchReady, 0);
    checkOutput("full_rdata", instrRdata, 32'h1111_1113);
    checkOutput("full_addr", instrAddr, 32'h500);
    stepClock();
    applyStimulus(1'b1, 32'h4444_4443, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("stall_valid", instrValid, 1);
    checkOutput("stall_rdata", instrRdata, 32'h1111_1113);
    checkOutput("full_pop_fready", fetchReady, 0);
    stepClock();
    checkOutput("pop1_fready", fetchReady, 1);
    checkOutput("pop1_rdata", instrRdata, 32'h2222_2223);
    checkOutput("pop1_addr", instrAddr, 32'h504);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("pop2_rdata", instrRdata, 32'h3333_3333);
    checkOutput("pop2_addr", instrAddr, 32'h508);
    stepClock();
    checkOutput("pop3_rdata", instrRdata, 32'h4444_4443);
    checkOutput("pop3_addr", instrAddr, 32'h50C);
    stepClock();
    checkOutput("drain_valid", instrValid, 0);
    checkOutput("drain_addr", instrAddr, 32'h510);

    // PC wrap and ignored bit 0 of the branch target
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    stepClock();
    checkOutput("wrap_baddr", instrAddr, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_valid", instrValid, 1);
    checkOutput("wrap_rdata", instrRdata, 32'h0000_0001);
    checkOutput("wrap_comp", instrCompressed, 1);
    stepClock();
    checkOutput("wrap_addr", instrAddr, 0);
    checkOutput("wrap_empty", instrValid, 0);

    // Bus error halts until the next branch
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("err_valid", instrValid, 1);
    checkOutput("err_flag", instrBusErr, 1);
    checkOutput("err_comp", instrCompressed, 0);
    checkOutput("err_addr", instrAddr, 32'h300);
    stepClock();
    checkOutput("halt_valid", instrValid, 0);
    checkOutput("halt_fready", fetchReady, 0);
    checkOutput("halt_err", instrBusErr, 0);
    checkOutput("halt_addr", instrAddr, 32'h300);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("unhalt_fready", fetchReady, 1);
    checkOutput("unhalt_valid", instrValid, 0);
    checkOutput("unhalt_addr", instrAddr, 32'h400);
    stepClock();
    checkOutput("unhalt_empty", instrValid, 0);

    // Branch in the same cycle as a push and a pop
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 32'h5555_5553, 1'b0, 1'b1, 32'h600, 1'b1);
    checkOutput("brpp_pre_valid", instrValid, 1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("brpp_valid", instrValid, 0);
    checkOutput("brpp_addr", instrAddr, 32'h600);
    checkOutput("brpp_fready", fetchReady, 1);
    stepClock();
    checkOutput("brpp_dropped", instrValid, 0);

    // Asynchronous reset with two words buffered
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("prerst_valid", instrValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", instrValid, 0);
    checkOutput("arst_addr", instrAddr, 0);
    checkOutput("arst_fready", fetchReady, 1);
    checkOutput("arst_rdata", instrRdata, 0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("postrst_valid", instrValid, 0);
    checkOutput("postrst_addr", instrAddr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
